multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS main control FSM. Sequences PC, instruction/data memory, IR, register file and ALU
//  over FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps, replacing single-cycle combinational decode.
//  Holds a one-shot request/ack handshake with a shared synchronous memory port and aborts stalled accesses.
//  op/funct come from the IR, which holds them stable from DECODE until the next FETCH completes.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles a memory request may wait for mem_ack before abort (>=2)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  op           in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ack      in   1  memory completes the access this cycle
//  mem_req      out  1  memory access request
//  mem_we       out  1  memory write (valid with mem_req)
//  iord         out  1  0: address=PC, 1: address=ALUOut
//  ir_write     out  1  load IR
//  pc_write     out  1  load PC
//  pc_src       out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  0: rt, 1: rd
//  mem_to_reg   out  1  0: ALUOut, 1: MDR
//  alu_src_a    out  1  0: PC, 1: rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  state        out  4  current state encoding, for debug
//  ill_op       out  1  1-cycle pulse: unknown op in DECODE or unknown funct in EXEC
//  bus_err      out  1  1-cycle registered pulse: memory access aborted on timeout
// BEHAVIOUR
//  - Registered state plus wait counter; all other outputs are Moore decode of state, except pc_write/ir_write,
//    which also depend on mem_ack/zero. While rst=1, every output is forced 0. Reset state is FETCH(0),
//    wait counter is 0, and bus_err is 0. Asserting rst mid-instruction aborts it; no further writes occur.
//  - Defaults, where not listed: all enables 0, pc_src 00, alu_src_a 0, alu_src_b 00, alu_control 010.
//  - States:
//    0 FETCH: mem_req=1, iord=0, alu_src_b=01, add. On mem_ack: ir_write=1 and pc_write=1 in the same cycle; next DECODE.
//    1 DECODE: alu_src_b=11, add (branch target to ALUOut).
//      Next by op: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP.
//      Any other op: ill_op=1, next FETCH.
//    2 MEMADR: alu_src_a=1, alu_src_b=10, add. op=100011 goes to MEMRD, otherwise to MEMWR.
//    3 MEMRD: mem_req=1, iord=1. On mem_ack, next MEMWB.
//    4 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
//    5 MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ack, next FETCH.
//    6 EXEC: alu_src_a=1, alu_src_b=00.
//      alu_control by funct: 100000 to 010, 100010 to 110, 100100 to 000, 100101 to 001, 101010 to 111.
//      Other funct: alu_control 010, ill_op=1, and EXEC still proceeds. Next ALUWB.
//    7 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
//    8 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero. Next FETCH.
//    9 ADDIEX: alu_src_a=1, alu_src_b=10, add. Next 10 ADDIWB.
//    10 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
//    11 JUMP: pc_src=10, pc_write=1. Next FETCH.
//    12-15 unused: decode as defaults, next FETCH.
//  - Latency: R-type/addi/lw take 4/4/5 cycles plus memory waits; sw/beq/j take 4/3/3 cycles plus memory waits.
//  - mem_req is held high until mem_ack. mem_ack is ignored outside FETCH/MEMRD/MEMWR.
//  - Wait counter: cleared on every state change. Increments each cycle a wait state sees mem_ack=0.
//    When the counter is TIMEOUT_CYCLES-1 and mem_ack=0: next state FETCH, bus_err=1 on the next cycle,
//    no ir/pc/reg write. mem_ack arriving on that same cycle wins: normal completion, no bus_err.
// TESTING
//  1. rst=1 mid-MEMRD -> all outputs 0 immediately; after release: state=0, mem_req=1.
//  2. add $3,$1,$2 with mem_ack 1 cycle after each req -> states 0,0,1,6,7; alu_control=010 in EXEC; reg_dst=1 and reg_write in ALUWB.
//  3. lw, op=100011, ack delayed 3 cycles in MEMRD -> MEMRD held 4 cycles with iord=1, mem_req=1; then MEMWB with mem_to_reg=1.
//  4. beq with zero=0, then with zero=1 -> pc_write 0, then 1 in BRANCH with pc_src=01; j: pc_write=1, pc_src=10.
//  5. mem_ack never asserted in FETCH with TIMEOUT_CYCLES=16 -> bus_err pulse on cycle 17, state 0, ir_write never 1.
//  6. op=111111 -> ill_op=1 for the single DECODE cycle, then FETCH; funct=000000 in EXEC -> ill_op=1, alu_control=010.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with one-shot memory request/ack handshake and timeout abort.
// Outputs are decoded from the registered state; pc_write/ir_write also follow mem_ack/zero.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       ill_op,
    output logic       bus_err
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t         cur;
    state_t         nxt;
    logic [CW-1:0]  wait_cnt;
    logic           bus_err_q;
    logic           in_wait;
    logic           timeout;

    logic       r_mem_req, r_mem_we, r_iord, r_ir_write, r_pc_write;
    logic [1:0] r_pc_src, r_alu_src_b;
    logic       r_reg_write, r_reg_dst, r_mem_to_reg, r_alu_src_a, r_ill_op;
    logic [2:0] r_alu_control;

    assign in_wait = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    // A late ack on the last allowed cycle still completes the access.
    assign timeout = in_wait && !mem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        nxt           = S_FETCH;
        r_mem_req     = 1'b0;
        r_mem_we      = 1'b0;
        r_iord        = 1'b0;
        r_ir_write    = 1'b0;
        r_pc_write    = 1'b0;
        r_pc_src      = 2'b00;
        r_reg_write   = 1'b0;
        r_reg_dst     = 1'b0;
        r_mem_to_reg  = 1'b0;
        r_alu_src_a   = 1'b0;
        r_alu_src_b   = 2'b00;
        r_alu_control = 3'b010;
        r_ill_op      = 1'b0;
        case (cur)
            S_FETCH: begin
                r_mem_req   = 1'b1;
                r_alu_src_b = 2'b01;
                r_ir_write  = mem_ack;
                r_pc_write  = mem_ack;
                nxt         = mem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                r_alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default: begin
                        r_ill_op = 1'b1;
                        nxt      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = 2'b10;
                nxt         = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                r_mem_req = 1'b1;
                r_iord    = 1'b1;
                nxt       = mem_ack ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                r_reg_write  = 1'b1;
                r_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                r_mem_req = 1'b1;
                r_mem_we  = 1'b1;
                r_iord    = 1'b1;
                nxt       = mem_ack ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                r_alu_src_a = 1'b1;
                nxt         = S_ALUWB;
                case (funct)
                    6'b100000: r_alu_control = 3'b010;
                    6'b100010: r_alu_control = 3'b110;
                    6'b100100: r_alu_control = 3'b000;
                    6'b100101: r_alu_control = 3'b001;
                    6'b101010: r_alu_control = 3'b111;
                    default:   r_ill_op      = 1'b1;
                endcase
            end
            S_ALUWB: begin
                r_reg_write = 1'b1;
                r_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                r_alu_src_a   = 1'b1;
                r_alu_control = 3'b110;
                r_pc_src      = 2'b01;
                r_pc_write    = zero;
            end
            S_ADDIEX: begin
                r_alu_src_a = 1'b1;
                r_alu_src_b = 2'b10;
                nxt         = S_ADDIWB;
            end
            S_ADDIWB: r_reg_write = 1'b1;
            S_JUMP: begin
                r_pc_src   = 2'b10;
                r_pc_write = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_FETCH;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (timeout) begin
                cur      <= S_FETCH;
                wait_cnt <= '0;
            end else if (nxt != cur) begin
                cur      <= nxt;
                wait_cnt <= '0;
            end else if (in_wait && !mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Reset silences every output combinationally so an aborted instruction writes nothing.
    assign mem_req     = r_mem_req     & ~rst;
    assign mem_we      = r_mem_we      & ~rst;
    assign iord        = r_iord        & ~rst;
    assign ir_write    = r_ir_write    & ~rst;
    assign pc_write    = r_pc_write    & ~rst;
    assign pc_src      = rst ? 2'b00 : r_pc_src;
    assign reg_write   = r_reg_write   & ~rst;
    assign reg_dst     = r_reg_dst     & ~rst;
    assign mem_to_reg  = r_mem_to_reg  & ~rst;
    assign alu_src_a   = r_alu_src_a   & ~rst;
    assign alu_src_b   = rst ? 2'b00 : r_alu_src_b;
    assign alu_control = rst ? 3'b000 : r_alu_control;
    assign state       = rst ? 4'd0 : cur;
    assign ill_op      = r_ill_op      & ~rst;
    assign bus_err     = bus_err_q     & ~rst;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction-level reference model with random ops and memory delays.
module tb_multicycle_ctrl;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src, alu_src_b;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ill_op, bus_err;
    logic [2:0] alu_control;
    logic [3:0] state;

    int compared = 0;
    int mismatched = 0;
    bit exp_berr = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .state(state), .ill_op(ill_op), .bus_err(bus_err)
    );

    wire [16:0] obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_control, ill_op};

    // Control word expected for a step, straight from the instruction-step table.
    function automatic logic [16:0] exp_out(int st, bit ack, bit z, logic [5:0] o, logic [5:0] f);
        logic req = 0, we = 0, ia = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, ill = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [2:0] ac = 3'b010;
        case (st)
            0: begin req = 1; sb = 1; irw = ack; pcw = ack; end
            1: begin sb = 3; ill = !(o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02}); end
            2: begin sa = 1; sb = 2; end
            3: begin req = 1; ia = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin req = 1; we = 1; ia = 1; end
            6: begin
                sa = 1;
                case (f)
                    6'b100000: ac = 3'b010;
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ill = 1;
                endcase
            end
            7: begin rw = 1; rd = 1; end
            8: begin sa = 1; ac = 3'b110; ps = 1; pcw = z; end
            9: begin sa = 1; sb = 2; end
            10: rw = 1;
            11: begin ps = 2; pcw = 1; end
            default: ;
        endcase
        return {req, we, ia, irw, pcw, ps, rw, rd, m2r, sa, sb, ac, ill};
    endfunction

    // One clock of stimulus: drive ack, check mid-cycle, advance to just after the next edge.
    task automatic cycle(input int es, input bit ack, input bit to, input string nm);
        logic [16:0] e;
        mem_ack = ack;
        @(negedge clk);
        e = exp_out(es, ack, zero, op, funct);
        compared++;
        if (state !== 4'(es)) begin
            mismatched++;
            $display("FAIL %s state got=%0d exp=%0d", nm, state, es);
        end
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("FAIL %s outputs st=%0d got=%h exp=%h", nm, es, obs, e);
        end
        compared++;
        if (bus_err !== exp_berr) begin
            mismatched++;
            $display("FAIL %s bus_err got=%b exp=%b", nm, bus_err, exp_berr);
        end
        exp_berr = to;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction; memory steps wait d cycles for ack (abort after T cycles).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                             input int d_fetch, input int d_mem, input string nm);
        int q[$];
        op = o; funct = f; zero = z;
        case (o)
            6'h23:   q = '{0, 1, 2, 3, 4};
            6'h2b:   q = '{0, 1, 2, 5};
            6'h00:   q = '{0, 1, 6, 7};
            6'h04:   q = '{0, 1, 8};
            6'h08:   q = '{0, 1, 9, 10};
            6'h02:   q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
        foreach (q[i]) begin
            if (q[i] == 0 || q[i] == 3 || q[i] == 5) begin
                int d = (q[i] == 0) ? d_fetch : d_mem;
                for (int k = 0; k < T; k++) begin
                    bit ack = (k == d);
                    bit to = !ack && (k == T - 1);
                    cycle(q[i], ack, to, nm);
                    if (ack) break;
                    if (to) return;
                end
            end else begin
                cycle(q[i], 1'($urandom_range(1)), 1'b0, nm);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        compared++;
        if ({obs, state, bus_err} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_hold got=%h exp=0", {obs, state, bus_err});
        end
        @(posedge clk); #1;
        rst = 0;
        exp_berr = 0;
        op = 6'h23;
        cycle(0, 1, 0, "rst_fetch");
        cycle(1, 0, 0, "rst_decode");
        cycle(2, 0, 0, "rst_memadr");
        mem_ack = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        #1;
        compared++;
        if ({obs, state, bus_err} !== 22'd0) begin
            mismatched++;
            $display("FAIL reset_mid_memrd got=%h exp=0", {obs, state, bus_err});
        end
        @(posedge clk); #1;
        rst = 0;
        cycle(0, 0, 0, "reset_release");
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'b100000, 0, 0, 0, "add_finish");
        run_instr(6'h00, 6'b100000, 0, 1, 0, "add");
        run_instr(6'h00, 6'b100010, 0, 0, 0, "sub");
        run_instr(6'h00, 6'b100100, 0, 2, 0, "and");
        run_instr(6'h00, 6'b100101, 0, 0, 0, "or");
        run_instr(6'h00, 6'b101010, 1, 0, 0, "slt");
    endtask

    task automatic test_memory();
        run_instr(6'h23, 6'h11, 0, 0, 3, "lw_delay3");
        run_instr(6'h2b, 6'h00, 0, 1, 2, "sw_delay2");
        run_instr(6'h2b, 6'h00, 0, 0, T - 1, "sw_ack_at_limit");
    endtask

    task automatic test_branch_jump();
        run_instr(6'h04, 6'h00, 0, 0, 0, "beq_nz");
        run_instr(6'h04, 6'h00, 1, 0, 0, "beq_z");
        run_instr(6'h02, 6'h00, 0, 0, 0, "jump");
        run_instr(6'h08, 6'h00, 0, 0, 0, "addi");
    endtask

    task automatic test_timeout();
        run_instr(6'h00, 6'b100000, 0, 40, 0, "fetch_timeout");
        run_instr(6'h23, 6'h00, 0, 0, 40, "memrd_timeout");
        run_instr(6'h2b, 6'h00, 0, 0, T, "memwr_timeout");
        run_instr(6'h00, 6'b100000, 0, 0, 0, "after_timeout");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'h00, 0, 0, 0, "ill_op_decode");
        run_instr(6'h00, 6'b000000, 0, 0, 0, "ill_funct_exec");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3f};
        logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 80; n++) begin
            logic [5:0] o = ($urandom_range(9) == 0) ? 6'($urandom) : ops[$urandom_range(6)];
            logic [5:0] f = ($urandom_range(7) == 0) ? 6'($urandom) : fns[$urandom_range(5)];
            int df = ($urandom_range(12) == 0) ? $urandom_range(T + 4, T - 2) : $urandom_range(3);
            int dm = ($urandom_range(12) == 0) ? $urandom_range(T + 4, T - 2) : $urandom_range(3);
            run_instr(o, f, 1'($urandom_range(1)), df, dm, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_memory();
        test_branch_jump();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
